// File: rtl/switch_allocator_wh_pkg.sv
// Shared NoC router parameters and switch-allocator types.
// The optional SA_PERF_CNT_EN build of switch_allocator_wh uses these types too.
package switch_allocator_wh_pkg;

  localparam int unsigned PORT_NUM  = 5;
  localparam int unsigned VC_NUM    = 2;
  localparam int unsigned VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef logic [PORT_SIZE-1:0] port_t;
  typedef logic [VC_SIZE-1:0]   vc_t;

  // Wormhole ownership of one output port.
  typedef struct packed {
    logic  valid;
    port_t in;
    vc_t   vc;
  } sa_lock_t;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/switch_allocator_wh_if.sv
// Request/grant bundle between the input VC buffers, the allocator and the crossbar.
interface switch_allocator_wh_if;
  import switch_allocator_wh_pkg::*;

  logic  [PORT_NUM-1:0][VC_NUM-1:0]    req;
  port_t [PORT_NUM-1:0][VC_NUM-1:0]    out_port;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]    is_tail;
  logic  [PORT_NUM-1:0]                out_ready;
  logic  [PORT_NUM-1:0]                valid_sel;
  logic  [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel;
  logic  [PORT_NUM-1:0]                xbar_valid;
  logic  [PORT_NUM-1:0][PORT_SIZE-1:0] xbar_sel;

  // Requester side (input block / crossbar control).
  modport master (
    output req, out_port, is_tail, out_ready,
    input  valid_sel, vc_sel, xbar_valid, xbar_sel
  );

  // Allocator side.
  modport slave (
    input  req, out_port, is_tail, out_ready,
    output valid_sel, vc_sel, xbar_valid, xbar_sel
  );

endinterface

// File: rtl/switch_allocator_wh_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  logic [IW-1:0] cand;

  // Scan requesters in rotating order from the pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!any_grant && req[cand]) begin
        any_grant   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator_wh.sv
// Separable input-first switch allocator with wormhole output locking.
// Optional SA_PERF_CNT_EN adds per-output grant and conflict counters.
module switch_allocator_wh
  import switch_allocator_wh_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  switch_allocator_wh_if.slave         sa
`ifdef SA_PERF_CNT_EN
  ,
  output logic [PORT_NUM-1:0][31:0]    grant_cnt,
  output logic [PORT_NUM-1:0][31:0]    conflict_cnt
`endif
);

  sa_lock_t [PORT_NUM-1:0]                lock;
  logic     [PORT_NUM-1:0][VC_SIZE-1:0]   in_ptr;
  logic     [PORT_NUM-1:0][PORT_SIZE-1:0] out_ptr;

  logic     [PORT_NUM-1:0][VC_NUM-1:0]    elig;
  port_t                                  el_o;

  logic     [PORT_NUM-1:0][VC_NUM-1:0]    s1_gnt;
  logic     [PORT_NUM-1:0][VC_SIZE-1:0]   s1_idx;
  logic     [PORT_NUM-1:0]                s1_any;
  port_t    [PORT_NUM-1:0]                s1_tgt;
  logic     [PORT_NUM-1:0]                s1_tail;

  logic     [PORT_NUM-1:0][PORT_NUM-1:0]  s2_req;   // [output][input]
  logic     [PORT_NUM-1:0][PORT_NUM-1:0]  s2_gnt;   // [output][input]
  logic     [PORT_NUM-1:0][PORT_SIZE-1:0] s2_idx;
  logic     [PORT_NUM-1:0]                s2_any;

  logic     [PORT_NUM-1:0]                vs_c;
  port_t    [PORT_NUM-1:0]                g_in;
  vc_t      [PORT_NUM-1:0]                g_vc;
  logic     [PORT_NUM-1:0]                g_tail;

  // VC eligibility: ready request, credit on target, and output free or owned by this VC.
  always_comb begin
    elig = '0;
    el_o = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        el_o = sa.out_port[i][v];
        elig[i][v] = !rst && sa.req[i][v] && (32'(el_o) < PORT_NUM) && sa.out_ready[el_o] &&
                     (!lock[el_o].valid ||
                      (lock[el_o].in == PORT_SIZE'(i) && lock[el_o].vc == VC_SIZE'(v)));
      end
    end
  end

  // Stage 1: one VC per input.
  for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_s1
    rr_arbiter #(.N(VC_NUM)) u_arb (
      .req       (elig[gi]),
      .ptr       (in_ptr[gi]),
      .grant     (s1_gnt[gi]),
      .grant_idx (s1_idx[gi]),
      .any_grant (s1_any[gi])
    );
  end

  // Stage-1 winner's target output and tail flag; build stage-2 request matrix.
  always_comb begin
    s1_tgt  = '0;
    s1_tail = '0;
    s2_req  = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      s1_tgt[i]  = sa.out_port[i][s1_idx[i]];
      s1_tail[i] = |(s1_gnt[i] & sa.is_tail[i]);
    end
    for (int unsigned o = 0; o < PORT_NUM; o++) begin
      for (int unsigned i = 0; i < PORT_NUM; i++) begin
        s2_req[o][i] = s1_any[i] && (s1_tgt[i] == PORT_SIZE'(o));
      end
    end
  end

  // Stage 2: one input per output; stage-1 losers simply wait.
  for (genvar go = 0; go < PORT_NUM; go++) begin : g_s2
    rr_arbiter #(.N(PORT_NUM)) u_arb (
      .req       (s2_req[go]),
      .ptr       (out_ptr[go]),
      .grant     (s2_gnt[go]),
      .grant_idx (s2_idx[go]),
      .any_grant (s2_any[go])
    );
  end

  // Grant outputs and per-output view of the winning input/VC.
  always_comb begin
    vs_c          = '0;
    sa.vc_sel     = '0;
    sa.xbar_valid = '0;
    sa.xbar_sel   = '0;
    g_in          = '0;
    g_vc          = '0;
    g_tail        = '0;
    for (int unsigned o = 0; o < PORT_NUM; o++) begin
      vs_c = vs_c | s2_gnt[o];
      if (s2_any[o]) begin
        sa.xbar_valid[o] = 1'b1;
        sa.xbar_sel[o]   = s2_idx[o];
      end
      g_in[o]   = s2_idx[o];
      g_vc[o]   = s1_idx[s2_idx[o]];
      g_tail[o] = s1_tail[s2_idx[o]];
    end
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (vs_c[i]) sa.vc_sel[i] = s1_idx[i];
    end
    sa.valid_sel = vs_c;
  end

  // Pointer and lock update; pointers only advance on grants to unlocked outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ptr  <= '0;
      out_ptr <= '0;
      lock    <= '0;
    end else begin
      for (int unsigned o = 0; o < PORT_NUM; o++) begin
        if (s2_any[o]) begin
          if (!lock[o].valid) begin
            out_ptr[o]       <= PORT_SIZE'(wrap_inc(32'(g_in[o]), PORT_NUM));
            in_ptr[g_in[o]]  <= VC_SIZE'(wrap_inc(32'(g_vc[o]), VC_NUM));
          end
          if (g_tail[o]) lock[o] <= '0;
          else           lock[o] <= '{valid: 1'b1, in: g_in[o], vc: g_vc[o]};
        end
      end
    end
  end

`ifdef SA_PERF_CNT_EN
  // Saturating grant / stage-2 conflict counters per output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int unsigned o = 0; o < PORT_NUM; o++) begin
        if (s2_any[o] && grant_cnt[o] != '1) grant_cnt[o] <= grant_cnt[o] + 32'd1;
        if ($countones(s2_req[o]) > 1 && conflict_cnt[o] != '1)
          conflict_cnt[o] <= conflict_cnt[o] + 32'd1;
      end
    end
  end
`else
  // Allocation only; no counter state in this build.
`endif

  // Grant consistency: one input per output, grant points back at a matching VC.
  for (genvar go = 0; go < PORT_NUM; go++) begin : g_chk
    assert property (@(posedge clk) disable iff (rst) $countones(s2_gnt[go]) <= 1);
    assert property (@(posedge clk) disable iff (rst)
      sa.xbar_valid[go] |-> (sa.valid_sel[sa.xbar_sel[go]] &&
        sa.out_port[sa.xbar_sel[go]][sa.vc_sel[sa.xbar_sel[go]]] == PORT_SIZE'(go)));
  end

  // Each granted input feeds exactly one output.
  assert property (@(posedge clk) disable iff (rst)
    $countones(sa.valid_sel) == $countones(sa.xbar_valid));

endmodule

// File: tb/tb_switch_allocator_wh.sv
// Self-checking bench for switch_allocator_wh: directed scenarios plus random traffic
// against a behavioural allocation model.
module tb_switch_allocator_wh;
  import switch_allocator_wh_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  switch_allocator_wh_if bus ();

`ifdef SA_PERF_CNT_EN
  logic [PORT_NUM-1:0][31:0] grant_cnt;
  logic [PORT_NUM-1:0][31:0] conflict_cnt;
  switch_allocator_wh dut (.clk(clk), .rst(rst), .sa(bus),
                           .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt));
`else
  switch_allocator_wh dut (.clk(clk), .rst(rst), .sa(bus));
`endif

  always #5 clk = ~clk;

  // Model state: rotating priorities and wormhole owners as plain integers.
  int m_in_ptr [PORT_NUM];
  int m_out_ptr[PORT_NUM];
  bit m_lv     [PORT_NUM];
  int m_li     [PORT_NUM];
  int m_lvc    [PORT_NUM];
  int win      [PORT_NUM];   // chosen VC per input, -1 none
  int gin      [PORT_NUM];   // granted input per output, -1 none

  logic [PORT_NUM-1:0]                e_vs, e_xv, obs_vs, obs_xv;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   e_vc, obs_vc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] e_xs, obs_xs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < PORT_NUM; k++) begin
      m_in_ptr[k] = 0; m_out_ptr[k] = 0; m_lv[k] = 0; m_li[k] = 0; m_lvc[k] = 0;
    end
  endtask

  function automatic bit vc_ok(input int i, input int v);
    int o;
    o = int'(bus.out_port[i][v]);
    if (!bus.req[i][v] || o >= PORT_NUM) return 0;
    if (!bus.out_ready[o]) return 0;
    return !m_lv[o] || (m_li[o] == i && m_lvc[o] == v);
  endfunction

  task automatic model_eval();
    e_vs = '0; e_xv = '0; e_vc = '0; e_xs = '0;
    for (int k = 0; k < PORT_NUM; k++) begin win[k] = -1; gin[k] = -1; end
    if (!rst) begin
      for (int i = 0; i < PORT_NUM; i++)
        for (int k = 0; k < VC_NUM; k++) begin
          int v;
          v = (m_in_ptr[i] + k) % VC_NUM;
          if (win[i] < 0 && vc_ok(i, v)) win[i] = v;
        end
      for (int o = 0; o < PORT_NUM; o++)
        for (int k = 0; k < PORT_NUM; k++) begin
          int i;
          i = (m_out_ptr[o] + k) % PORT_NUM;
          if (gin[o] < 0 && win[i] >= 0 && int'(bus.out_port[i][win[i]]) == o) gin[o] = i;
        end
      for (int o = 0; o < PORT_NUM; o++)
        if (gin[o] >= 0) begin
          e_xv[o]      = 1'b1;
          e_xs[o]      = PORT_SIZE'(gin[o]);
          e_vs[gin[o]] = 1'b1;
          e_vc[gin[o]] = VC_SIZE'(win[gin[o]]);
        end
    end
  endtask

  task automatic model_commit();
    for (int o = 0; o < PORT_NUM; o++)
      if (gin[o] >= 0) begin
        int i, v;
        i = gin[o]; v = win[i];
        if (!m_lv[o]) begin
          m_out_ptr[o] = (i + 1) % PORT_NUM;
          m_in_ptr[i]  = (v + 1) % VC_NUM;
        end
        if (bus.is_tail[i][v]) m_lv[o] = 0;
        else begin m_lv[o] = 1; m_li[o] = i; m_lvc[o] = v; end
      end
  endtask

  task automatic check_now();
    model_eval();
    obs_vs = bus.valid_sel; obs_vc = bus.vc_sel; obs_xv = bus.xbar_valid; obs_xs = bus.xbar_sel;
    chk("valid_sel", 64'(obs_vs), 64'(e_vs));
    chk("vc_sel", 64'(obs_vc), 64'(e_vc));
    chk("xbar_valid", 64'(obs_xv), 64'(e_xv));
    chk("xbar_sel", 64'(obs_xs), 64'(e_xs));
  endtask

  // One cycle: inputs already set at negedge, sample mid-phase, advance the model at posedge.
  task automatic step();
    #1;
    check_now();
    @(posedge clk);
    if (!rst) model_commit();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.out_port = '0; bus.is_tail = '0; bus.out_ready = '1;
  endtask

  task automatic set_vc(input int i, input int v, input bit r, input int op, input bit t);
    bus.req[i][v] = r; bus.out_port[i][v] = PORT_SIZE'(op); bus.is_tail[i][v] = t;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);

    // Reset held: outputs silent, even with a live request.
    step();
    set_vc(0, 0, 1, 2, 0);
    step();
    rst = 1'b0;
    clear_inputs();
    step();
    step();

    // Two inputs contend for output 3 with head-tail flits: grant alternates.
    set_vc(0, 0, 1, 3, 1);
    set_vc(1, 0, 1, 3, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("alt_sel3", 64'(obs_xs[3]), 64'(k % 2));
      chk("alt_v3", 64'(obs_xv[3]), 64'd1);
    end
`ifdef SA_PERF_CNT_EN
    chk("conflict3", 64'(conflict_cnt[3]), 64'd4);
`endif
    clear_inputs();
    step();

    // Both VCs of input 2 to one output, then to different outputs: VC choice alternates.
    set_vc(2, 0, 1, 4, 1);
    set_vc(2, 1, 1, 4, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("vcalt_same", 64'(obs_vc[2]), 64'(k % 2));
    end
    set_vc(2, 1, 1, 1, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("vcalt_diff", 64'(obs_vc[2]), 64'(k % 2));
      chk("one_grant", 64'(obs_vs), 64'(5'b00100));
    end
    clear_inputs();
    step();

    // Wormhole: input 0 VC1 owns output 2 until its tail; input 4 waits.
    set_vc(0, 1, 1, 2, 0);
    step();
    chk("head_grant", 64'(obs_xs[2]), 64'd0);
    set_vc(4, 0, 1, 2, 1);
    repeat (2) begin
      step();
      chk("body_owner", 64'(obs_xs[2]), 64'd0);
      chk("body_block", 64'(obs_vs[4]), 64'd0);
    end
    set_vc(0, 1, 1, 2, 1);
    step();
    chk("tail_grant", 64'(obs_xs[2]), 64'd0);
    set_vc(0, 1, 0, 2, 0);
    step();
    chk("after_tail_sel", 64'(obs_xs[2]), 64'd4);
    chk("after_tail_v", 64'(obs_xv[2]), 64'd1);
    clear_inputs();
    step();

    // Owner stalls while locked: nobody else gets output 2.
    set_vc(0, 1, 1, 2, 0);
    step();
    set_vc(0, 1, 0, 2, 0);
    set_vc(4, 0, 1, 2, 1);
    repeat (3) begin
      step();
      chk("stall_nogrant", 64'(obs_xv[2]), 64'd0);
    end
    set_vc(0, 1, 1, 2, 1);
    step();
    chk("resume_sel", 64'(obs_xs[2]), 64'd0);
    chk("resume_v", 64'(obs_xv[2]), 64'd1);
    clear_inputs();
    step();

    // Asynchronous reset mid-packet clears the lock.
    set_vc(0, 1, 1, 2, 0);
    step();
    #2 rst = 1'b1;
    #1 check_now();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_vc(0, 1, 0, 2, 0);
    set_vc(4, 0, 1, 2, 1);
    step();
    chk("post_rst_sel", 64'(obs_xs[2]), 64'd4);
    chk("post_rst_v", 64'(obs_xv[2]), 64'd1);
    clear_inputs();
    step();

    // No credit on output 1: no grant, pointer held; then round-robin from the pointer.
    bus.out_ready[1] = 1'b0;
    set_vc(0, 0, 1, 1, 1);
    set_vc(3, 0, 1, 1, 1);
    repeat (2) begin
      step();
      chk("no_credit", 64'(obs_xv[1]), 64'd0);
    end
    bus.out_ready[1] = 1'b1;
    step();
    chk("credit_first", 64'(obs_xs[1]), 64'd0);
    step();
    chk("credit_second", 64'(obs_xs[1]), 64'd3);
    clear_inputs();
    step();

    // Random traffic with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < PORT_NUM; i++)
        for (int v = 0; v < VC_NUM; v++)
          set_vc(i, v, $urandom_range(0, 3) != 0, int'($urandom_range(0, PORT_NUM - 1)),
                 $urandom_range(0, 2) == 0);
      for (int o = 0; o < PORT_NUM; o++) bus.out_ready[o] = $urandom_range(0, 5) != 0;
      if (n == 200) begin
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
